// File: rtl/aes_pkg.sv
// Shared AES helpers: block constants, FSM encoding, GF(2^8) column mix, row shift, NK/NR check.
package aes_pkg;

  localparam int NB      = 4;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are big-endian: row 0 sits in col[31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte k of the block lives at [BLOCK_W-1-8k -: 8]; byte r+4c is row r, column c.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BLOCK_W-1-8*(r+4*c) -: 8] = s[BLOCK_W-1-8*(r+4*((c+r)%NB)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic bit nk_nr_legal(input int nk, input int nr);
    return (nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry a occupies bits [2047-8a -: 8], i.e. bit index {~a, 3'b111}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[{~a_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES forward cipher, one round per clock, start/busy/done handshake.
// Define AES_ROUND_TAP_EN to expose per-round tap_round/tap_state debug registers.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BLOCK_W-1:0]         block_in,
  input  logic [BLOCK_W*(NR+1)-1:0]  w,
  output logic                       busy,
  output logic                       done,
  output logic [BLOCK_W-1:0]         block_out
`ifdef AES_ROUND_TAP_EN
  ,
  output logic [3:0]                 tap_round,
  output logic [BLOCK_W-1:0]         tap_state
`endif
);

  localparam logic [3:0] NR_Q = 4'(NR);

  generate
    if (!nk_nr_legal(NK, NR)) begin : g_bad_cfg
      $error("aes_round_engine: illegal NK/NR pairing");
    end
  endgenerate

  aes_fsm_e             fsm_q, fsm_d;
  logic [3:0]           round_q, round_d;
  logic [BLOCK_W-1:0]   state_q, state_d;
  logic [BLOCK_W-1:0]   out_q, out_d;
  logic [BLOCK_W-1:0]   sub_bytes, shifted, mixed, round_key, round_res;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
        .a_i (state_q[8*i +: 8]),
        .s_o (sub_bytes[8*i +: 8])
      );
    end
  endgenerate

  assign shifted = shift_rows(sub_bytes);

  generate
    for (genvar c = 0; c < NB; c++) begin : g_mix
      assign mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
    end
  endgenerate

  // Explicit mux keeps the key select in range even if round_q were ever out of bounds.
  always_comb begin
    round_key = '0;
    for (int r = 0; r <= NR; r++) begin
      if (round_q == 4'(r)) round_key = w[BLOCK_W*r +: BLOCK_W];
    end
  end

  assign round_res = ((round_q == NR_Q) ? shifted : mixed) ^ round_key;

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    out_d   = out_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = block_in ^ w[BLOCK_W-1:0];
          round_d = 4'd1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = round_res;
        if (round_q < NR_Q) round_d = round_q + 4'd1;
        if (round_q == NR_Q) begin
          out_d = round_res;
          fsm_d = S_DONE;
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign busy      = (fsm_q == S_RUN);
  assign done      = (fsm_q == S_DONE);
  assign block_out = out_q;

`ifdef AES_ROUND_TAP_EN
  logic [3:0]         tap_round_q;
  logic [BLOCK_W-1:0] tap_state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_round_q <= '0;
      tap_state_q <= '0;
    end else if (fsm_q == S_RUN) begin
      tap_round_q <= round_q;
      tap_state_q <= round_res;
    end
  end

  assign tap_round = tap_round_q;
  assign tap_state = tap_state_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine: AES-128 and AES-256 instances against a byte-level AES model.
module tb_aes_round_engine;

  typedef logic [7:0] u8;
  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [127:0]  blk_a = '0, blk_b = '0;
  logic [1407:0] w_a = '0;
  logic [1919:0] w_b = '0;
  logic          busy_a, done_a, busy_b, done_b;
  logic [127:0]  out_a, out_b;
`ifdef AES_ROUND_TAP_EN
  logic [3:0]    tr_a, tr_b;
  logic [127:0]  ts_a, ts_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  u8    sbox_m[256];

  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_engine #(.NK(4), .NR(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .block_in(blk_a), .w(w_a),
    .busy(busy_a), .done(done_a), .block_out(out_a)
`ifdef AES_ROUND_TAP_EN
    , .tap_round(tr_a), .tap_state(ts_a)
`endif
  );

  aes_round_engine #(.NK(8), .NR(14)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .block_in(blk_b), .w(w_b),
    .busy(busy_b), .done(done_b), .block_out(out_b)
`ifdef AES_ROUND_TAP_EN
    , .tap_round(tr_b), .tap_state(ts_b)
`endif
  );

  // ---------------- reference model ----------------
  function automatic u8 gmul(input u8 a, input u8 b);
    u8 p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? u8'((a << 1) ^ 8'h1b) : u8'(a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic u8 rotl8(input u8 b, input int n);
    return u8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      u8 inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(u8'(x), u8'(y)) == 8'h01) inv = u8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   wd[60];
    logic [31:0]   t;
    u8             rc = 8'h01;
    logic [1919:0] r = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) wd[i] = key[255-32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        wd[i] = wd[i-nk] ^ t;
      end
    end
    for (int k = 0; k < 4*(nr+1); k++) r[128*(k/4) + 32*(3-k%4) +: 32] = wd[k];
    return r;
  endfunction

  // State after round 'upto' (upto == nr gives the ciphertext).
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [1919:0] w,
                                          input int nr, input int upto);
    u8 s[16];
    u8 t[16];
    u8 a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[127-8*i -: 8];
    for (int r = 1; r <= upto; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[128*r + 127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done: got done=1 expected no pending block");
      end else begin
        e = q_a.pop_front();
        chk("a_block_out", out_a, e.ct);
        chk("a_latency", 128'(cyc - e.acc), 128'(10));
        chk("a_busy_at_done", {127'b0, busy_a}, 128'(0));
      end
    end
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done: got done=1 expected no pending block");
      end else begin
        e = q_b.pop_front();
        chk("b_block_out", out_b, e.ct);
        chk("b_latency", 128'(cyc - e.acc), 128'(14));
        chk("b_busy_at_done", {127'b0, busy_b}, 128'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_a(input logic [127:0] pt, input logic [127:0] ct);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1; blk_a = pt;
    @(negedge clk);
    start_a = 1'b0; blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    e.ct = ct; e.acc = cyc;
    q_a.push_back(e);
  endtask

  task automatic run_b(input logic [127:0] pt, input logic [127:0] ct);
    exp_t e;
    @(negedge clk);
    start_b = 1'b1; blk_b = pt;
    @(negedge clk);
    start_b = 1'b0; blk_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    e.ct = ct; e.acc = cyc;
    q_b.push_back(e);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d expected 0", q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1919:0] wx;
    logic [255:0]  key;
    logic [127:0]  pt, cur, last;
    exp_t          e;

    build_sbox();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_busy", {127'b0, busy_a}, 128'(0));
    chk("rst_a_done", {127'b0, done_a}, 128'(0));
    chk("rst_a_out", out_a, 128'(0));
    chk("rst_b_busy", {127'b0, busy_b}, 128'(0));
    chk("rst_b_done", {127'b0, done_b}, 128'(0));
    chk("rst_b_out", out_b, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 Appendix B
    wx = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    w_a = wx[1407:0];
    run_a(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_drain(100);

    // FIPS-197 C.1
    wx = expand(C1_KEY, 4, 10);
    w_a = wx[1407:0];
    run_a(C1_PT, C1_CT);
`ifdef AES_ROUND_TAP_EN
    @(negedge clk);
    chk("tap_round1_state", ts_a, 128'h89d810e8855ace682d1843d8cb128fe4);
    chk("tap_round1_idx", {124'b0, tr_a}, 128'(1));
`endif
    wait_drain(100);

    // FIPS-197 C.3
    wx = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    w_b = wx;
    run_b(C1_PT, 128'h8ea2b7ca516745bfeafc49904b496089);
    wait_drain(100);

    // Random keys and blocks on both engines concurrently
    for (int n = 0; n < 6; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      wx = expand({key[255:128], 128'h0}, 4, 10);
      w_a = wx[1407:0];
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_a(pt, cipher(pt, wx, 10, 10));
      wx = expand(key, 8, 14);
      w_b = wx;
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_b(pt, cipher(pt, wx, 14, 14));
      wait_drain(100);
    end

    // start held high with block_in changing every cycle: accepts every 12 edges
    wx = expand(C1_KEY, 4, 10);
    w_a = wx[1407:0];
    last = '0;
    @(negedge clk);
    start_a = 1'b1;
    blk_a = C1_PT;
    for (int j = 0; j < 40; j++) begin
      cur = blk_a;
      @(negedge clk);
      if (j % 12 == 0) begin
        e.ct = (j == 0) ? C1_CT : cipher(cur, wx, 10, 10);
        e.acc = cyc;
        q_a.push_back(e);
        last = e.ct;
      end
      blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    start_a = 1'b0;
    wait_drain(100);

    // block_out holds with no start while inputs change
    for (int j = 0; j < 4; j++) begin
      blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      w_a[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      w_a[1407:1280] = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      chk("hold_block_out", out_a, last);
      chk("hold_busy", {127'b0, busy_a}, 128'(0));
    end

    // Reset mid-operation around round 5, then restart C.1
    w_a = wx[1407:0];
    run_a(C1_PT, C1_CT);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q_a.delete();
    chk("midrst_out", out_a, 128'(0));
    chk("midrst_busy", {127'b0, busy_a}, 128'(0));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("midrst_done", {127'b0, done_a}, 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_a(C1_PT, C1_CT);
    wait_drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
